serial_eq_ctrl: RTL and testbench

- Controller that decides whether two WIDTH-bit operands are equal by stepping them two bits per cycle through one shared eq2 2-bit equality slice.
- Sits between a requester (switch or host FSM) and the LED output.
- Provides a start/busy/done handshake, exits early on the first mismatching slice, and holds the result on ledpin.

---
 rtl/serial_eq_ctrl_pkg.sv | 10 +
 rtl/serial_eq_ctrl_eq2.sv | 12 +
 rtl/serial_eq_ctrl.sv | 101 ++++++++++
 tb/tb_serial_eq_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_eq_ctrl_pkg.sv
// Shared constants for the serial equality controller: FSM encodings and slice width.
package serial_eq_ctrl_pkg;

  localparam int SLICE_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_eq_ctrl_eq2.sv
// eq2: purely combinational 2-bit equality slice; ledpin is high when a == b.
module eq2
  import serial_eq_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic               ledpin
);

  assign ledpin = (a == b);

endmodule

// File: rtl/serial_eq_ctrl.sv
// Serial equality controller: walks two WIDTH-bit operands through one eq2 slice,
// two bits per cycle, LSB slice first, exiting early on the first mismatch.
module serial_eq_ctrl
  import serial_eq_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int N     = WIDTH / 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic             ledpin,
  output logic [IDX_W-1:0] slice_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             equal_q, equal_d;
  logic             ledpin_q, ledpin_d;
  logic             slice_eq;

  eq2 u_eq2 (
    .a      (a_sh_q[SLICE_W-1:0]),
    .b      (b_sh_q[SLICE_W-1:0]),
    .ledpin (slice_eq)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    cnt_d    = cnt_q;
    equal_d  = equal_q;
    ledpin_d = ledpin_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d   = a_in;
          b_sh_d   = b_in;
          cnt_d    = '0;
          equal_d  = 1'b0;
          ledpin_d = 1'b0;
          state_d  = ST_CMP;
        end
      end
      ST_CMP: begin
        if (!slice_eq) begin
          equal_d = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == LAST_IDX) begin
          equal_d  = 1'b1;
          ledpin_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          // Zero fill keeps the upper bits deterministic once consumed.
          a_sh_d = a_sh_q >> SLICE_W;
          b_sh_d = b_sh_q >> SLICE_W;
          cnt_d  = cnt_q + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      cnt_q    <= '0;
      equal_q  <= 1'b0;
      ledpin_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      cnt_q    <= cnt_d;
      equal_q  <= equal_d;
      ledpin_q <= ledpin_d;
    end
  end

  // Handshake outputs decode registered state only, so they cannot glitch.
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign equal     = equal_q;
  assign ledpin    = ledpin_q;
  assign slice_idx = (state_q == ST_CMP) ? cnt_q : '0;

endmodule

// File: tb/tb_serial_eq_ctrl.sv
// Bench for serial_eq_ctrl: timeline model checked every cycle plus directed literal checks.
module tb_serial_eq_ctrl;

  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start;
  logic [WIDTH-1:0] a_in, b_in;
  logic             busy, done, equal, ledpin;
  logic [1:0]       slice_idx;

  serial_eq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .equal     (equal),
    .ledpin    (ledpin),
    .slice_idx (slice_idx)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_mismatch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    for (int i = 0; i < N; i++)
      if (a[2*i +: 2] !== b[2*i +: 2]) return i;
    return N;
  endfunction

  // Model: an accepted op lasts m_len edges in compare, then one DONE cycle.
  bit m_active = 1'b0;
  int m_rel = 0;
  int m_len = 0;
  bit m_match = 1'b0;
  bit m_eq = 1'b0;
  bit m_led = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    bit was_idle;
    int fm;
    if (reset) begin
      m_active = 1'b0;
      m_rel    = 0;
      m_len    = 0;
      m_eq     = 1'b0;
      m_led    = 1'b0;
    end else begin
      was_idle = !m_active;
      if (m_active) begin
        m_rel++;
        if (m_rel == m_len) begin
          m_eq  = m_match;
          m_led = m_match;
        end else if (m_rel > m_len) begin
          m_active = 1'b0;
        end
      end
      if (was_idle && start === 1'b1) begin
        fm       = first_mismatch(a_in, b_in);
        m_match  = (fm == N);
        m_len    = m_match ? N : fm + 1;
        m_active = 1'b1;
        m_rel    = 0;
        m_eq     = 1'b0;
        m_led    = 1'b0;
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", busy, m_active);
      check("done", done, m_active && (m_rel == m_len));
      check("slice_idx", slice_idx, (m_active && m_rel < m_len) ? m_rel : 0);
      check("equal", equal, m_eq);
      check("ledpin", ledpin, m_led);
    end
  end

  // lat = edges from the accepting edge to the edge that ends the done cycle.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int lat, output bit eq_seen);
    lat     = -1;
    eq_seen = 1'b0;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_in  = WIDTH'($urandom);
    b_in  = WIDTH'($urandom);
    for (int e = 1; e <= 20; e++) begin
      if (done === 1'b1) begin
        lat     = e;
        eq_seen = equal;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat;
    bit eqs;
    int dones;
    logic [WIDTH-1:0] a, b;
    int fm;

    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #1 reset = 1'b1;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_equal", equal, 0);
    check("reset_ledpin", ledpin, 0);
    check("reset_slice_idx", slice_idx, 0);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Full match: result and LED hold afterwards.
    run_op(8'hA5, 8'hA5, lat, eqs);
    check("t1_latency", lat, 5);
    check("t1_equal", eqs, 1);
    check("t1_ledpin", ledpin, 1);
    repeat (3) @(negedge clk);
    check("t1_equal_hold", equal, 1);
    check("t1_ledpin_hold", ledpin, 1);

    // Mismatch at slice 0, 1, 2 and 3 (last slice really compared).
    run_op(8'hA5, 8'hA4, lat, eqs);
    check("t2_latency", lat, 2);
    check("t2_equal", eqs, 0);
    check("t2_ledpin", ledpin, 0);
    run_op(8'hA5, 8'hA1, lat, eqs);
    check("s1_latency", lat, 3);
    run_op(8'hA5, 8'hB5, lat, eqs);
    check("s2_latency", lat, 4);
    run_op(8'hA5, 8'h25, lat, eqs);
    check("t3_latency", lat, 5);
    check("t3_equal", eqs, 0);

    // Starts during CMP and DONE are dropped; the one after DONE is taken.
    @(negedge clk);
    a_in  = 8'hA5;
    b_in  = 8'hA5;
    start = 1'b1;
    @(posedge clk);
    dones = 0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (e == 5) check("t4_equal_first", equal, 1);
      if (e == 7) begin
        check("t4_ledpin_cleared", ledpin, 0);
        check("t4_busy_second", busy, 1);
      end
      if (e == 8) begin
        check("t4_done_second", done, 1);
        check("t4_equal_second", equal, 0);
      end
      start = (e == 2 || e == 5 || e == 6);
      a_in  = 8'h00;
      b_in  = 8'hFF;
    end
    start = 1'b0;
    check("t4_done_pulses", dones, 2);

    // Reset mid-operation aborts at once.
    run_op(8'h3C, 8'h3C, lat, eqs);
    @(negedge clk);
    a_in  = 8'hA5;
    b_in  = 8'hA5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_equal", equal, 0);
    check("t5_ledpin", ledpin, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_op(8'h3C, 8'h3C, lat, eqs);
    check("t5_after_latency", lat, 5);
    check("t5_after_equal", eqs, 1);

    // Sweep: every A against itself and every single-bit flip, then random pairs.
    for (int ai = 0; ai < 256; ai++) begin
      for (int j = -1; j < WIDTH; j++) begin
        a = WIDTH'(ai);
        b = (j < 0) ? a : (a ^ (WIDTH'(1) << j));
        run_op(a, b, lat, eqs);
        fm = first_mismatch(a, b);
        check("sweep_equal", eqs, (a == b));
        check("sweep_latency", lat, (fm == N) ? N + 1 : fm + 2);
      end
    end
    for (int r = 0; r < 300; r++) begin
      a = WIDTH'($urandom_range(0, 255));
      b = (r % 4 == 0) ? a : WIDTH'($urandom_range(0, 255));
      run_op(a, b, lat, eqs);
      fm = first_mismatch(a, b);
      check("rand_equal", eqs, (a == b));
      check("rand_latency", lat, (fm == N) ? N + 1 : fm + 2);
    end

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
